uart_rx_oversample: RTL and testbench

- Oversampling UART receiver; serial-to-parallel counterpart of the team's UART transmitter.
- Shares the same baud-rate tick generator (s_tick at OVERSAMPLE x baud).
- Frame format: 1 start bit, DATA_BITS data bits LSB-first, optional parity bit, 1 stop bit.
- Received byte is held in a register with a valid/ack handshake to the host side; framing and overrun errors are flagged.

---
 rtl/uart_rx_oversample.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_oversample.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// uart_rx_oversample: oversampling UART receiver (start, DATA_BITS data LSB-first,
// optional parity, one stop bit) with a valid/ack hold register for the host.
// Optional parity checking is compiled in with `define UART_RX_PARITY_EN, which
// also adds parameter PARITY_ODD (0 = even, 1 = odd).
module uart_rx_oversample #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter int PARITY_ODD = 0
`endif
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 s_tick,
  input  logic                 rx_in,
  input  logic                 rx_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 frame_err,
  output logic                 overrun_err,
  output logic                 parity_err
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int NW = $clog2(DATA_BITS);

  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_ONE  = SW'(1);
  localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);
  localparam logic [NW-1:0] N_ONE  = NW'(1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   r_sync1;
  logic                   r_sync2;
  logic                   w_rx_s;
  logic [SW-1:0]          r_s;
  logic [NW-1:0]          r_n;
  logic [DATA_BITS-1:0]   r_shift;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_valid;
  logic                   r_done;
  logic                   r_frame_err;
  logic                   r_overrun_err;
  logic                   w_busy;
  logic                   w_tick_mid;
  logic                   w_tick_end;
  logic                   w_frame_end;
  logic                   w_good;
  logic                   w_load;

  assign w_rx_s      = r_sync2;
  assign w_tick_mid  = s_tick && (r_s == S_MID);
  assign w_tick_end  = s_tick && (r_s == S_END);
  assign w_frame_end = (r_state == ST_STOP) && w_tick_end;
  assign w_good      = w_frame_end && w_rx_s;
  // A pending ack in the load cycle frees the register, so the new word wins.
  assign w_load      = w_good && (!r_valid || rx_ack);

  // Two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state: start detect, mid-bit sampling points, re-arm at mid stop
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (!w_rx_s) w_state_nxt = ST_START;
      ST_START:  if (w_tick_mid) w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
`ifdef UART_RX_PARITY_EN
      ST_DATA:   if (w_tick_end && (r_n == N_LAST)) w_state_nxt = ST_PARITY;
      ST_PARITY: if (w_tick_end) w_state_nxt = ST_STOP;
`else
      ST_DATA:   if (w_tick_end && (r_n == N_LAST)) w_state_nxt = ST_STOP;
`endif
      ST_STOP:   if (w_tick_end) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_busy = 1'b0;
    if (r_state != ST_IDLE) w_busy = 1'b1;
  end

  // Tick and bit counters; both hold on cycles without s_tick
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_s <= '0;
      r_n <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_s <= '0;
          r_n <= '0;
        end
        ST_START: begin
          if (s_tick) r_s <= (r_s == S_MID) ? '0 : r_s + S_ONE;
        end
        ST_DATA: begin
          if (s_tick) begin
            if (r_s == S_END) begin
              r_s <= '0;
              r_n <= (r_n == N_LAST) ? '0 : r_n + N_ONE;
            end else begin
              r_s <= r_s + S_ONE;
            end
          end
        end
        default: begin
          if (s_tick) r_s <= (r_s == S_END) ? '0 : r_s + S_ONE;
        end
      endcase
    end
  end

  // Data bits arrive LSB-first, so each sample enters at the MSB and moves down
  always_ff @(posedge clk) begin
    if ((r_state == ST_DATA) && w_tick_end)
      r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
  end

  // End-of-frame pulses and the host-side hold register
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_data        <= '0;
      r_valid       <= 1'b0;
      r_done        <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      r_done        <= w_frame_end;
      r_frame_err   <= w_frame_end && !w_rx_s;
      r_overrun_err <= w_good && r_valid && !rx_ack;
      if (w_load) begin
        r_data  <= r_shift;
        r_valid <= 1'b1;
      end else if (rx_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;

  function automatic logic parity_mismatch(input logic [DATA_BITS-1:0] d, input logic p);
    return p ^ (^d) ^ (PARITY_ODD != 0);
  endfunction

  // Latch the parity verdict in PARITY; report it with the frame's done pulse
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if ((r_state == ST_PARITY) && w_tick_end)
        r_par_bad <= parity_mismatch(r_shift, w_rx_s);
      r_parity_err <= w_frame_end && r_par_bad;
    end
  end

  assign parity_err = r_parity_err;
`else
  assign parity_err = 1'b0;
`endif

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign busy        = w_busy;
  assign done        = r_done;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Bench for uart_rx_oversample: directed frames from the test plan plus random
// frames, each outcome predicted by a frame-level model of the receiver.
module tb_uart_rx_oversample;

  localparam int OS      = 16;
  localparam int DB      = 8;
  localparam int BIT_CLK = OS * 4;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = 1'b1;
`else
  localparam bit PAR_ON = 1'b0;
`endif
  // Ticks from entering START to the mid-stop sample that loads the word.
  localparam int ACK_TICK = OS / 2 + OS * DB + OS * (PAR_ON ? 2 : 1);

  logic          clk;
  logic          rstN;
  logic          s_tick;
  logic          rx_in;
  logic          rx_ack;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          done;
  logic          frame_err;
  logic          overrun_err;
  logic          parity_err;

  uart_rx_oversample dut (
    .clk         (clk),
    .rstN        (rstN),
    .s_tick      (s_tick),
    .rx_in       (rx_in),
    .rx_ack      (rx_ack),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .done        (done),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
    .parity_err  (parity_err)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       ferr;
    logic       oerr;
    logic       perr;
    logic       busy;
  } ev_t;

  ev_t        ev_q[$];
  ev_t        mon_ev;
  int         stray = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  logic       m_valid;
  logic [7:0] m_data;
  logic [7:0] rd;
  logic       rs;
  logic       rp;
  logic       hit;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-clk tick every 4 clk: 16 ticks per bit gives 64 clk per bit.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  // Record the outputs seen in every done cycle; error pulses alone are stray.
  always @(negedge clk) begin
    if (done) begin
      mon_ev.data  = rx_data;
      mon_ev.valid = rx_valid;
      mon_ev.ferr  = frame_err;
      mon_ev.oerr  = overrun_err;
      mon_ev.perr  = parity_err;
      mon_ev.busy  = busy;
      ev_q.push_back(mon_ev);
    end else if (frame_err || overrun_err || parity_err) begin
      stray++;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_v, input logic par_flip);
    rx_in = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx_in = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (PAR_ON) begin
      rx_in = (^d) ^ par_flip;
      repeat (BIT_CLK) @(negedge clk);
    end
    // A low stop bit is released early so the re-detected start is a false one.
    rx_in = stop_v;
    repeat (BIT_CLK * 3 / 4) @(negedge clk);
    rx_in = 1'b1;
    repeat (BIT_CLK / 4) @(negedge clk);
  endtask

  task automatic gap();
    repeat (2 * BIT_CLK) @(negedge clk);
  endtask

  task automatic ack_pulse(input string tag);
    @(negedge clk);
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    m_valid = 1'b0;
    chk({tag, ".ack_clears"}, rx_valid, 1'b0);
  endtask

  // Frame-level model: predict the done-cycle outputs, then compare.
  task automatic expect_frame(input string tag, input logic [7:0] d, input logic stop_v,
                              input logic par_flip, input logic ack_at_load);
    ev_t exp_e;
    ev_t got_e;
    exp_e.ferr = !stop_v;
    exp_e.perr = PAR_ON & par_flip;
    exp_e.oerr = stop_v & m_valid & !ack_at_load;
    if (stop_v && (!m_valid || ack_at_load)) begin
      m_data  = d;
      m_valid = 1'b1;
    end
    exp_e.data  = m_data;
    exp_e.valid = m_valid;
    exp_e.busy  = 1'b0;
    chk({tag, ".done_seen"}, (ev_q.size() > 0), 1'b1);
    if (ev_q.size() > 0) begin
      got_e = ev_q.pop_front();
      chk({tag, ".rx_data"},     got_e.data,  exp_e.data);
      chk({tag, ".rx_valid"},    got_e.valid, exp_e.valid);
      chk({tag, ".frame_err"},   got_e.ferr,  exp_e.ferr);
      chk({tag, ".overrun_err"}, got_e.oerr,  exp_e.oerr);
      chk({tag, ".parity_err"},  got_e.perr,  exp_e.perr);
      chk({tag, ".busy"},        got_e.busy,  exp_e.busy);
    end
  endtask

  task automatic run_frame(input string tag, input logic [7:0] d, input logic stop_v,
                           input logic par_flip);
    send_frame(d, stop_v, par_flip);
    gap();
    expect_frame(tag, d, stop_v, par_flip, 1'b0);
    chk({tag, ".extra_done"}, ev_q.size(), 0);
  endtask

  // Raise rx_ack for exactly the cycle whose tick is the mid-stop sample.
  task automatic ack_at_load(output logic got_hit);
    int k;
    k = 0;
    got_hit = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      #1;
      if (busy) break;
    end
    if (busy) begin
      for (int i = 0; i < 4000; i++) begin
        if (s_tick) k++;
        if (k == ACK_TICK) begin
          rx_ack = 1'b1;
          @(negedge clk);
          #1;
          rx_ack = 1'b0;
          got_hit = 1'b1;
          break;
        end
        @(negedge clk);
        #1;
      end
    end
  endtask

  initial begin
    rstN    = 1'b1;
    rx_in   = 1'b1;
    rx_ack  = 1'b0;
    m_valid = 1'b0;
    m_data  = 8'h00;
    #2 rstN = 1'b0;
    #1;
    chk("rst.rx_data",     rx_data,     0);
    chk("rst.rx_valid",    rx_valid,    0);
    chk("rst.busy",        busy,        0);
    chk("rst.done",        done,        0);
    chk("rst.frame_err",   frame_err,   0);
    chk("rst.overrun_err", overrun_err, 0);
    chk("rst.parity_err",  parity_err,  0);
    repeat (4) @(negedge clk);
    rstN = 1'b1;
    repeat (8) @(negedge clk);

    run_frame("ferr_3C", 8'h3C, 1'b0, 1'b0);

    rx_in = 1'b0;
    repeat (16) @(negedge clk);
    chk("glitch.busy_high", busy, 1);
    rx_in = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
    chk("glitch.busy_low", busy, 0);
    chk("glitch.no_done", ev_q.size(), 0);
    chk("glitch.rx_valid", rx_valid, m_valid);

    run_frame("good_A5", 8'hA5, 1'b1, 1'b0);
    ack_pulse("ack_A5");

    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    gap();
    expect_frame("b2b_11", 8'h11, 1'b1, 1'b0, 1'b0);
    expect_frame("b2b_22", 8'h22, 1'b1, 1'b0, 1'b0);
    chk("b2b.extra_done", ev_q.size(), 0);

    fork
      send_frame(8'h5A, 1'b1, 1'b0);
      ack_at_load(hit);
    join
    gap();
    chk("ackload.timed", hit, 1);
    expect_frame("ackload_5A", 8'h5A, 1'b1, 1'b0, 1'b1);
    chk("ackload.valid_after", rx_valid, 1);

    rx_in = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx_in = 8'h7E >> i;
      repeat (BIT_CLK) @(negedge clk);
    end
    chk("midrst.busy_before", busy, 1);
    #3 rstN = 1'b0;
    rx_in = 1'b1;
    #1;
    chk("midrst.rx_data",  rx_data,  0);
    chk("midrst.rx_valid", rx_valid, 0);
    chk("midrst.busy",     busy,     0);
    chk("midrst.done",     done,     0);
    m_valid = 1'b0;
    m_data  = 8'h00;
    repeat (4) @(negedge clk);
    rstN = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst.no_done", ev_q.size(), 0);
    run_frame("after_rst_81", 8'h81, 1'b1, 1'b0);

`ifdef UART_RX_PARITY_EN
    ack_pulse("ack_par");
    run_frame("par_bad_07", 8'h07, 1'b1, 1'b1);
    chk("par_bad.rx_data", rx_data, 8'h07);
    ack_pulse("ack_par2");
    run_frame("par_ok_07", 8'h07, 1'b1, 1'b0);
`endif

    for (int f = 0; f < 12; f++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 4) != 0);
      rp = PAR_ON && ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) ack_pulse("rnd_ack");
      run_frame("rnd", rd, rs, rp);
      chk("rnd.rx_data_lvl",  rx_data,  m_data);
      chk("rnd.rx_valid_lvl", rx_valid, m_valid);
    end

    chk("stray_err_pulses", stray, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
